// File: rtl/counter_bcd_n.sv
// Cascaded BCD up/down counter with clear, parallel load, wrap-or-saturate
// terminal behaviour, sticky overflow and a sticky invalid-load flag.
module counter_bcd_n #(
  parameter int DIGITS = 4,
  parameter bit WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  ovf,
  output logic                  load_err
);

  localparam int W = 4 * DIGITS;

  function automatic logic [3:0] bcd_fix(input logic [3:0] d);
    return (d > 4'd9) ? 4'd0 : d;
  endfunction

  function automatic logic [3:0] bcd_step(input logic [3:0] d, input logic inc);
    if (inc) return (d == 4'd9) ? 4'd0 : d + 4'd1;
    else     return (d == 4'd0) ? 4'd9 : d - 4'd1;
  endfunction

  logic [W-1:0] stepped;
  logic [W-1:0] loaded;
  logic         bad_digit;
  logic         at_max;
  logic         at_zero;
  logic         at_term;
  logic         carry;

  // Ripple the borrow/carry across decades; a terminal step naturally wraps
  // to all-0 (up) or all-9 (down), which is exactly the WRAP result.
  always_comb begin
    stepped   = count;
    loaded    = '0;
    bad_digit = 1'b0;
    at_max    = 1'b1;
    at_zero   = 1'b1;
    carry     = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (carry) stepped[4*k +: 4] = bcd_step(count[4*k +: 4], up);
      carry     = carry & (up ? (count[4*k +: 4] == 4'd9) : (count[4*k +: 4] == 4'd0));
      at_max    = at_max  & (count[4*k +: 4] == 4'd9);
      at_zero   = at_zero & (count[4*k +: 4] == 4'd0);
      loaded[4*k +: 4] = bcd_fix(load_val[4*k +: 4]);
      bad_digit = bad_digit | (load_val[4*k +: 4] > 4'd9);
    end
  end

  assign at_term = up ? at_max : at_zero;
  assign tc      = en & at_term;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      ovf      <= 1'b0;
      load_err <= 1'b0;
    end else if (clr) begin
      count    <= '0;
      ovf      <= 1'b0;
      load_err <= 1'b0;
    end else if (load) begin
      count    <= loaded;
      ovf      <= 1'b0;
      load_err <= bad_digit;
    end else if (en) begin
      if (at_term) begin
        ovf <= 1'b1;
        if (WRAP) count <= stepped;
      end else begin
        count <= stepped;
      end
    end
  end

endmodule

// File: tb/tb_counter_bcd_n.sv
// Bench for counter_bcd_n: a wrapping and a saturating instance share stimulus
// and are compared against an integer-valued reference model.
module tb_counter_bcd_n;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int MAXV   = 9999;

  logic         clk = 1'b0;
  logic         reset, en, up, clr, load;
  logic [W-1:0] load_val;
  logic [W-1:0] count_w, count_s;
  logic         tc_w, tc_s, ovf_w, ovf_s, lerr_w, lerr_s;

  int n_cmp = 0;
  int n_err = 0;

  // index 0 models the wrapping instance, index 1 the saturating one
  int mval  [2];
  bit movf  [2];
  bit mlerr [2];

  always #5 clk = ~clk;

  counter_bcd_n #(.DIGITS(DIGITS), .WRAP(1'b1)) dut_w (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(count_w), .tc(tc_w), .ovf(ovf_w), .load_err(lerr_w));

  counter_bcd_n #(.DIGITS(DIGITS), .WRAP(1'b0)) dut_s (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(count_s), .tc(tc_s), .ovf(ovf_s), .load_err(lerr_s));

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r = '0;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic bit exp_tc(input int i);
    return en && (up ? (mval[i] == MAXV) : (mval[i] == 0));
  endfunction

  task automatic model_zero();
    for (int i = 0; i < 2; i++) begin
      mval[i] = 0; movf[i] = 0; mlerr[i] = 0;
    end
  endtask

  // Apply the effect of one rising edge to the model, then advance past it.
  task automatic cycle();
    int v, p, d;
    bit bad;
    for (int i = 0; i < 2; i++) begin
      if (clr) begin
        mval[i] = 0; movf[i] = 0; mlerr[i] = 0;
      end else if (load) begin
        v = 0; p = 1; bad = 0;
        for (int k = 0; k < DIGITS; k++) begin
          d = int'((load_val >> (4*k)) & 16'hF);
          if (d > 9) begin bad = 1; d = 0; end
          v += d * p;
          p *= 10;
        end
        mval[i] = v; movf[i] = 0; mlerr[i] = bad;
      end else if (en) begin
        if (up && mval[i] == MAXV) begin
          movf[i] = 1;
          if (i == 0) mval[i] = 0;
        end else if (!up && mval[i] == 0) begin
          movf[i] = 1;
          if (i == 0) mval[i] = MAXV;
        end else begin
          mval[i] = up ? mval[i] + 1 : mval[i] - 1;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    en = 0; up = 1; clr = 0; load = 0; load_val = '0;
  endtask

  task automatic test_reset();
    reset = 0; idle();
    en = 1; up = 0; load = 1; clr = 0; load_val = 16'h1234;
    model_zero();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({count_w, ovf_w, lerr_w} !== {16'h0000, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL reset_hold_w: got %h/%b/%b want 0000/0/0", count_w, ovf_w, lerr_w);
    end
    n_cmp++;
    if ({count_s, ovf_s, lerr_s} !== {16'h0000, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL reset_hold_s: got %h/%b/%b want 0000/0/0", count_s, ovf_s, lerr_s);
    end
    n_cmp++;
    if ({tc_w, tc_s} !== 2'b11) begin
      n_err++; $display("FAIL reset_tc_down: got %b%b want 11", tc_w, tc_s);
    end
    up = 1; #1;
    n_cmp++;
    if ({tc_w, tc_s} !== 2'b00) begin
      n_err++; $display("FAIL reset_tc_up: got %b%b want 00", tc_w, tc_s);
    end
    idle();
    @(posedge clk); #1;
    reset = 1;
  endtask

  task automatic test_count_up();
    en = 1; up = 1;
    for (int c = 0; c < 10; c++) begin
      #1;
      n_cmp++;
      if (tc_w !== 1'b0) begin
        n_err++; $display("FAIL up10_tc cycle %0d: got %b want 0", c, tc_w);
      end
      cycle();
    end
    n_cmp++;
    if ({count_w, ovf_w} !== {16'h0010, 1'b0}) begin
      n_err++; $display("FAIL up10_count: got %h/%b want 0010/0", count_w, ovf_w);
    end
    idle();
  endtask

  task automatic test_wrap();
    load = 1; load_val = 16'h9998; cycle();
    load = 0; en = 1; up = 1;
    #1;
    n_cmp++;
    if (tc_w !== 1'b0) begin
      n_err++; $display("FAIL wrap_tc_9998: got %b want 0", tc_w);
    end
    cycle();
    n_cmp++;
    if ({count_w, tc_w, ovf_w} !== {16'h9999, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL wrap_9999: got %h/%b/%b want 9999/1/0", count_w, tc_w, ovf_w);
    end
    cycle();
    n_cmp++;
    if ({count_w, ovf_w} !== {16'h0000, 1'b1}) begin
      n_err++; $display("FAIL wrap_0000: got %h/%b want 0000/1", count_w, ovf_w);
    end
    n_cmp++;
    if ({count_s, ovf_s} !== {16'h9999, 1'b1}) begin
      n_err++; $display("FAIL sat_9999: got %h/%b want 9999/1", count_s, ovf_s);
    end
    for (int c = 0; c < 5; c++) begin
      cycle();
      n_cmp++;
      if ({ovf_w, ovf_s} !== 2'b11) begin
        n_err++; $display("FAIL ovf_sticky cycle %0d: got %b%b want 11", c, ovf_w, ovf_s);
      end
    end
    idle();
  endtask

  task automatic test_sat_down();
    clr = 1; cycle();
    clr = 0; en = 1; up = 0;
    #1;
    n_cmp++;
    if ({tc_w, tc_s} !== 2'b11) begin
      n_err++; $display("FAIL down_tc_zero: got %b%b want 11", tc_w, tc_s);
    end
    cycle();
    n_cmp++;
    if ({count_s, ovf_s} !== {16'h0000, 1'b1}) begin
      n_err++; $display("FAIL sat_down_hold: got %h/%b want 0000/1", count_s, ovf_s);
    end
    n_cmp++;
    if ({count_w, ovf_w} !== {16'h9999, 1'b1}) begin
      n_err++; $display("FAIL wrap_down: got %h/%b want 9999/1", count_w, ovf_w);
    end
    idle();
  endtask

  task automatic test_load_err();
    load = 1; load_val = 16'h1A3F; cycle();
    n_cmp++;
    if ({count_w, lerr_w, ovf_w} !== {16'h1030, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL load_bad: got %h/%b/%b want 1030/1/0", count_w, lerr_w, ovf_w);
    end
    load = 0; en = 1; up = 1; cycle();
    n_cmp++;
    if ({count_w, lerr_w} !== {16'h1031, 1'b1}) begin
      n_err++; $display("FAIL load_err_hold: got %h/%b want 1031/1", count_w, lerr_w);
    end
    en = 0; load = 1; load_val = 16'h1234; cycle();
    n_cmp++;
    if ({count_w, lerr_w} !== {16'h1234, 1'b0}) begin
      n_err++; $display("FAIL load_good: got %h/%b want 1234/0", count_w, lerr_w);
    end
    idle();
  endtask

  task automatic test_priority();
    load = 1; load_val = 16'h0500; cycle();
    clr = 1; load = 1; en = 1; up = 1; load_val = 16'h0777; cycle();
    n_cmp++;
    if ({count_w, ovf_w, lerr_w} !== {16'h0000, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL clr_priority: got %h/%b/%b want 0000/0/0", count_w, ovf_w, lerr_w);
    end
    clr = 0; cycle();
    n_cmp++;
    if (count_w !== 16'h0777) begin
      n_err++; $display("FAIL load_over_en: got %h want 0777", count_w);
    end
    idle();
  endtask

  task automatic test_direction();
    load = 1; load_val = 16'h0100; cycle();
    load = 0; en = 1;
    up = 0; cycle();
    n_cmp++;
    if (count_w !== 16'h0099) begin
      n_err++; $display("FAIL dir_down: got %h want 0099", count_w);
    end
    up = 1; cycle();
    n_cmp++;
    if (count_w !== 16'h0100) begin
      n_err++; $display("FAIL dir_up: got %h want 0100", count_w);
    end
    idle();
  endtask

  task automatic test_async_reset();
    load = 1; load_val = 16'h0998; cycle();
    load = 0; en = 1; up = 1; cycle();
    n_cmp++;
    if (count_w !== 16'h0999) begin
      n_err++; $display("FAIL pre_reset: got %h want 0999", count_w);
    end
    #2 reset = 0;
    #1;
    n_cmp++;
    if ({count_w, count_s} !== 32'h0) begin
      n_err++; $display("FAIL async_reset: got %h/%h want 0000/0000", count_w, count_s);
    end
    model_zero();
    #1 reset = 1;
    cycle();
    n_cmp++;
    if (count_w !== 16'h0001) begin
      n_err++; $display("FAIL resume: got %h want 0001", count_w);
    end
    idle();
  endtask

  task automatic test_random();
    logic [W-1:0] near [4];
    near[0] = 16'h9997; near[1] = 16'h0001; near[2] = 16'h0000; near[3] = 16'h9999;
    for (int c = 0; c < 400; c++) begin
      clr  = ($urandom_range(0, 29) == 0);
      load = ($urandom_range(0, 9) == 0);
      en   = ($urandom_range(0, 3) != 0);
      up   = ($urandom_range(0, 3) != 0) ^ (c >= 200);
      load_val = $urandom_range(0, 1) ? W'($urandom) : near[$urandom_range(0, 3)];
      #1;
      n_cmp++;
      if ({tc_w, tc_s} !== {exp_tc(0), exp_tc(1)}) begin
        n_err++; $display("FAIL rand_tc cycle %0d: got %b%b want %b%b", c, tc_w, tc_s, exp_tc(0), exp_tc(1));
      end
      cycle();
      n_cmp++;
      if ({count_w, ovf_w, lerr_w, count_s, ovf_s, lerr_s} !==
          {to_bcd(mval[0]), movf[0], mlerr[0], to_bcd(mval[1]), movf[1], mlerr[1]}) begin
        n_err++;
        $display("FAIL rand_state cycle %0d: got w=%h/%b/%b s=%h/%b/%b want w=%h/%b/%b s=%h/%b/%b",
                 c, count_w, ovf_w, lerr_w, count_s, ovf_s, lerr_s,
                 to_bcd(mval[0]), movf[0], mlerr[0], to_bcd(mval[1]), movf[1], mlerr[1]);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap();
    test_sat_down();
    test_load_err();
    test_priority();
    test_direction();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
